// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared definitions for the ALU operand stage: ALU opcode
//           encodings, RV32I major opcodes, operand-select enums, the
//           buffered stage payload and the register-register / immediate
//           funct3 decode helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int PKG_XLEN = 32;
   localparam int PKG_REGW = 5;

   // ALU opcode encodings
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_A    = 4'b0111;
   localparam logic [3:0] ALU_SHL  = 4'b1000;
   localparam logic [3:0] ALU_SHR  = 4'b1010;
   localparam logic [3:0] ALU_SHA  = 4'b1011;
   localparam logic [3:0] ALU_SLT  = 4'b1100;
   localparam logic [3:0] ALU_SLTU = 4'b1101;
   localparam logic [3:0] ALU_B    = 4'b1111;

   // RV32I major opcodes (instruction[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_PC   = 2'd1,
      A_ZERO = 2'd2
   } a_sel_t;

   typedef enum logic [1:0] {
      B_RS2  = 2'd0,
      B_IMM  = 2'd1,
      B_FOUR = 2'd2
   } b_sel_t;

   // One buffered instruction as presented to the ALU
   typedef struct packed {
      logic [PKG_XLEN-1:0] a;
      logic [PKG_XLEN-1:0] b;
      logic [PKG_XLEN-1:0] rs2_val;
      logic [PKG_XLEN-1:0] pc;
      logic [3:0]          alu_op;
      logic [PKG_REGW-1:0] rd;
      logic                wb_en;
      logic                illegal;
   } payload_t;

   // funct3 table shared by OP and OP-IMM. 'alt' selects SUB/SHA;
   // allow_sub is cleared for OP-IMM where 000 is always ADD.
   function automatic logic [3:0] arith_op(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       allow_sub);
      logic [3:0] op;
      op = ALU_ADD;
      case (funct3)
         3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SHL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SHA : ALU_SHR;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_decode
// Purpose : Combinational decode of opcode/funct fields into the ALU opcode,
//           operand selects, writeback enable and illegal flag.
// Ports   : opcode, funct3, funct7b5, imm_bit10 (shift-type bit for OP-IMM),
//           rd_nonzero  -> alu_op, a_sel, b_sel, wb_en, illegal
// Rev     : 1.0  initial release
// ============================================================================
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       imm_bit10,
   input  logic       rd_nonzero,
   output logic [3:0] alu_op,
   output a_sel_t     a_sel,
   output b_sel_t     b_sel,
   output logic       wb_en,
   output logic       illegal
);

   logic writes_rd;

   always_comb begin
      alu_op    = ALU_ADD;
      a_sel     = A_RS1;
      b_sel     = B_RS2;
      writes_rd = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_OP: begin
            alu_op    = arith_op(funct3, funct7b5, 1'b1);
            writes_rd = 1'b1;
         end
         OPC_OP_IMM: begin
            // immediate shifts carry the arithmetic flag in imm[10]
            alu_op    = arith_op(funct3, imm_bit10, 1'b0);
            b_sel     = B_IMM;
            writes_rd = 1'b1;
         end
         OPC_LUI: begin
            alu_op    = ALU_B;
            a_sel     = A_ZERO;
            b_sel     = B_IMM;
            writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            a_sel     = A_PC;
            b_sel     = B_IMM;
            writes_rd = 1'b1;
         end
         OPC_LOAD: begin
            b_sel     = B_IMM;
            writes_rd = 1'b1;
         end
         OPC_STORE: begin
            b_sel     = B_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            // ALU produces the link address pc+4
            a_sel     = A_PC;
            b_sel     = B_FOUR;
            writes_rd = 1'b1;
         end
         OPC_BRANCH: begin
            case (funct3[2:1])
               2'b10:   alu_op = ALU_SLT;
               2'b11:   alu_op = ALU_SLTU;
               default: alu_op = ALU_SUB;
            endcase
         end
         default: begin
            alu_op  = ALU_A;
            illegal = 1'b1;
         end
      endcase
   end

   assign wb_en = writes_rd & rd_nonzero;

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_operand_stage
// Purpose : ID/EX boundary stage. Resolves operands with EX/MEM and MEM/WB
//           forwarding, decodes the ALU opcode and presents the result
//           through a 2-entry skid buffer with valid/ready on both sides.
// Ports   : clk, rst_n (sync, active low), flush
//           in_*    : decoded instruction + register-file data, in_valid/ready
//           exmem_* / memwb_* : forwarding sources
//           out_valid/out_ready, alu_a, alu_b, alu_op, out_rs2_val, out_rd,
//           out_wb_en, out_pc, out_illegal : ALU-side payload
// Rev     : 1.0  initial release
// ============================================================================
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7b5,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [REGW-1:0] in_rd,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic            exmem_we,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_val,
   input  logic            memwb_we,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [REGW-1:0] out_rd,
   output logic            out_wb_en,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   // The payload struct is sized by the package; only 32/5 is supported.
   generate
      if (XLEN != PKG_XLEN || REGW != PKG_REGW) begin : g_width_check
         $error("alu_operand_stage supports only XLEN=32, REGW=5");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Forwarding: x0 is hard zero, younger producer (EX/MEM) wins
   // ---------------------------------------------------------------------
   function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] idx,
                                           input logic [XLEN-1:0] rf_val,
                                           input logic            ex_we,
                                           input logic [REGW-1:0] ex_rd,
                                           input logic [XLEN-1:0] ex_val,
                                           input logic            wb_we,
                                           input logic [REGW-1:0] wb_rd,
                                           input logic [XLEN-1:0] wb_val);
      logic [XLEN-1:0] v;
      if (idx == '0)
         v = '0;
      else if (ex_we && ex_rd == idx)
         v = ex_val;
      else if (wb_we && wb_rd == idx)
         v = wb_val;
      else
         v = rf_val;
      return v;
   endfunction

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign rs1_val = fwd(in_rs1, in_rs1_data, exmem_we, exmem_rd, exmem_val,
                        memwb_we, memwb_rd, memwb_val);
   assign rs2_val = fwd(in_rs2, in_rs2_data, exmem_we, exmem_rd, exmem_val,
                        memwb_we, memwb_rd, memwb_val);

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [3:0] dec_op;
   a_sel_t     dec_a_sel;
   b_sel_t     dec_b_sel;
   logic       dec_wb_en;
   logic       dec_illegal;
   logic       rd_nonzero;

   assign rd_nonzero = (in_rd != '0);

   alu_op_decode u_decode (
      .opcode     (in_opcode),
      .funct3     (in_funct3),
      .funct7b5   (in_funct7b5),
      .imm_bit10  (in_imm[10]),
      .rd_nonzero (rd_nonzero),
      .alu_op     (dec_op),
      .a_sel      (dec_a_sel),
      .b_sel      (dec_b_sel),
      .wb_en      (dec_wb_en),
      .illegal    (dec_illegal)
   );

   payload_t incoming;

   always_comb begin
      incoming = '0;
      case (dec_a_sel)
         A_PC:    incoming.a = in_pc;
         A_ZERO:  incoming.a = '0;
         default: incoming.a = rs1_val;
      endcase
      case (dec_b_sel)
         B_IMM:   incoming.b = in_imm;
         B_FOUR:  incoming.b = 32'd4;
         default: incoming.b = rs2_val;
      endcase
      incoming.rs2_val = rs2_val;
      incoming.pc      = in_pc;
      incoming.alu_op  = dec_op;
      incoming.rd      = in_rd;
      incoming.wb_en   = dec_wb_en;
      incoming.illegal = dec_illegal;
   end

   // ---------------------------------------------------------------------
   // Skid buffer: main_q drives the outputs, skid_q holds the entry that
   // arrived while the ALU was stalled. out_valid/in_ready are flops kept
   // in step with the state so in_ready never sees out_ready.
   // ---------------------------------------------------------------------
   state_t   state;
   payload_t main_q;
   payload_t skid_q;
   logic     valid_q;
   logic     ready_q;
   logic     accept;
   logic     consume;

   assign accept  = in_valid & ready_q;
   assign consume = valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else if (flush) begin
         state   <= S_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  main_q  <= incoming;
                  state   <= S_ONE;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            S_ONE: begin
               if (accept && consume) begin
                  main_q <= incoming;
               end else if (accept) begin
                  skid_q  <= incoming;
                  state   <= S_TWO;
                  valid_q <= 1'b1;
                  ready_q <= 1'b0;
               end else if (consume) begin
                  state   <= S_EMPTY;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            S_TWO: begin
               if (consume) begin
                  main_q  <= skid_q;
                  state   <= S_ONE;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= S_EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = ready_q;
   assign out_valid   = valid_q;
   assign alu_a       = main_q.a;
   assign alu_b       = main_q.b;
   assign alu_op      = main_q.alu_op;
   assign out_rs2_val = main_q.rs2_val;
   assign out_rd      = main_q.rd;
   assign out_wb_en   = main_q.wb_en;
   assign out_pc      = main_q.pc;
   assign out_illegal = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_operand_stage
// Purpose : Self-checking bench for alu_operand_stage. The driver pushes the
//           hand-computed expected payload on each accepted instruction; a
//           monitor pops and compares on every ALU-side handshake.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rs2v;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
      logic        chk_b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic        exmem_we, memwb_we;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_val, memwb_val;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, out_rs2_val, out_pc;
   logic [3:0]  alu_op;
   logic [4:0]  out_rd;
   logic        out_wb_en, out_illegal;

   int n_cmp  = 0;
   int n_fail = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   alu_operand_stage #(.XLEN(32), .REGW(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_pc(in_pc),
      .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
      .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_wb_en(out_wb_en),
      .out_pc(out_pc), .out_illegal(out_illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] rs2v, input logic [31:0] pc,
                               input logic [3:0] op, input logic [4:0] rd,
                               input logic wb, input logic ill, input logic chk_b);
      exp_t e;
      e.a = a; e.b = b; e.rs2v = rs2v; e.pc = pc; e.op = op;
      e.rd = rd; e.wb = wb; e.ill = ill; e.chk_b = chk_b;
      return e;
   endfunction

   // Monitor: every ALU-side handshake must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("alu_a", alu_a, e.a);
            if (e.chk_b) chk("alu_b", alu_b, e.b);
            chk("alu_op", {28'd0, alu_op}, {28'd0, e.op});
            chk("rs2_val", out_rs2_val, e.rs2v);
            chk("out_pc", out_pc, e.pc);
            chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            chk("wb_en", {31'd0, out_wb_en}, {31'd0, e.wb});
            chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
         end
      end
   end

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
      in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
      in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
   endtask

   // Holds in_valid until accepted, then records the expectation
   task automatic send(input exp_t e);
      int k;
      k = 0;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            break;
         end
         k++;
         if (k > 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain_left", q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] OPI = 7'b0010011;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      exmem_we = 1'b0; exmem_rd = '0; exmem_val = '0;
      memwb_we = 1'b0; memwb_rd = '0; memwb_val = '0;
      drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // ADD x3,x1,x2 with 1-cycle latency check
      drive(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h100);
      send(mk(32'd5, 32'd7, 32'd7, 32'h100, 4'b0000, 5'd3, 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;

      // SUB x4,x4,x5: EX/MEM beats MEM/WB
      exmem_we = 1'b1; exmem_rd = 5'd4; exmem_val = 32'd100;
      memwb_we = 1'b1; memwb_rd = 5'd4; memwb_val = 32'd50;
      drive(OP, 3'b000, 1'b1, 5'd4, 5'd5, 5'd4, 32'd1, 32'd3, 32'd0, 32'h104);
      send(mk(32'd100, 32'd3, 32'd3, 32'h104, 4'b0001, 5'd4, 1'b1, 1'b0, 1'b1));
      // XOR x7,x6,x8: MEM/WB supplies rs1
      memwb_rd = 5'd6; memwb_val = 32'h55;
      drive(OP, 3'b100, 1'b0, 5'd6, 5'd8, 5'd7, 32'd1, 32'h0F, 32'd0, 32'h108);
      send(mk(32'h55, 32'h0F, 32'h0F, 32'h108, 4'b0110, 5'd7, 1'b1, 1'b0, 1'b1));
      // STORE: forwarded store data, no writeback
      memwb_we = 1'b0; exmem_rd = 5'd9; exmem_val = 32'hAB;
      drive(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd9, 5'd5, 32'h1000, 32'h11, 32'd8, 32'h10C);
      send(mk(32'h1000, 32'd8, 32'hAB, 32'h10C, 4'b0000, 5'd5, 1'b0, 1'b0, 1'b1));
      exmem_we = 1'b0;
      // LOAD with rs2=0 ignoring nonzero read data
      drive(7'b0000011, 3'b010, 1'b0, 5'd2, 5'd0, 5'd6, 32'h2000, 32'h999, 32'hFFFFFFFC, 32'h110);
      send(mk(32'h2000, 32'hFFFFFFFC, 32'd0, 32'h110, 4'b0000, 5'd6, 1'b1, 1'b0, 1'b1));
      // AUIPC
      drive(7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h1000, 32'h200);
      send(mk(32'h200, 32'h1000, 32'd0, 32'h200, 4'b0000, 5'd8, 1'b1, 1'b0, 1'b1));
      // JAL: pc + 4
      drive(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h40, 32'h300);
      send(mk(32'h300, 32'd4, 32'd0, 32'h300, 4'b0000, 5'd1, 1'b1, 1'b0, 1'b1));
      // BLT -> SLT, BEQ -> SUB, BGEU -> SLTU
      drive(7'b1100011, 3'b100, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd9, 32'h10, 32'h304);
      send(mk(32'd3, 32'd9, 32'd9, 32'h304, 4'b1100, 5'd0, 1'b0, 1'b0, 1'b1));
      drive(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd9, 32'h10, 32'h308);
      send(mk(32'd3, 32'd9, 32'd9, 32'h308, 4'b0001, 5'd0, 1'b0, 1'b0, 1'b1));
      drive(7'b1100011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 32'd9, 32'h10, 32'h30C);
      send(mk(32'd3, 32'd9, 32'd9, 32'h30C, 4'b1101, 5'd0, 1'b0, 1'b0, 1'b1));
      drain();

      // Backpressure: two accepted, third stalls, outputs held
      out_ready = 1'b0;
      drive(OP, 3'b110, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 32'h500);
      send(mk(32'd1, 32'd2, 32'd2, 32'h500, 4'b0101, 5'd9, 1'b1, 1'b0, 1'b1));
      drive(OP, 3'b111, 1'b0, 5'd1, 5'd2, 5'd10, 32'd3, 32'd4, 32'd0, 32'h504);
      send(mk(32'd3, 32'd4, 32'd4, 32'h504, 4'b0100, 5'd10, 1'b1, 1'b0, 1'b1));
      drive(OP, 3'b011, 1'b0, 5'd1, 5'd2, 5'd11, 32'd5, 32'd6, 32'd0, 32'h508);
      in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_alu_a", alu_a, 32'd1);
      chk("hold_alu_op", {28'd0, alu_op}, 32'h5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(mk(32'd5, 32'd6, 32'd6, 32'h508, 4'b1101, 5'd11, 1'b1, 1'b0, 1'b1));
      drain();

      // Flush in state TWO with a concurrent incoming instruction
      out_ready = 1'b0;
      drive(OP, 3'b010, 1'b0, 5'd1, 5'd2, 5'd12, 32'd7, 32'd8, 32'd0, 32'h600);
      send(mk(32'd7, 32'd8, 32'd8, 32'h600, 4'b1100, 5'd12, 1'b1, 1'b0, 1'b1));
      drive(OP, 3'b001, 1'b0, 5'd1, 5'd2, 5'd13, 32'd1, 32'd3, 32'd0, 32'h604);
      send(mk(32'd1, 32'd3, 32'd3, 32'h604, 4'b1000, 5'd13, 1'b1, 1'b0, 1'b1));
      drive(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd14, 32'd99, 32'd1, 32'd0, 32'h608);
      in_valid = 1'b1; flush = 1'b1;
      q.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // LUI, SRAI, SRLI, ADDI x0, illegal opcode, rs1=x0 forwarding
      drive(7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd13, 32'hDEAD, 32'd0, 32'h12345000, 32'h400);
      send(mk(32'd0, 32'h12345000, 32'd0, 32'h400, 4'b1111, 5'd13, 1'b1, 1'b0, 1'b1));
      drive(OPI, 3'b101, 1'b0, 5'd1, 5'd0, 5'd2, 32'h80000000, 32'd0, 32'h405, 32'h404);
      send(mk(32'h80000000, 32'h405, 32'd0, 32'h404, 4'b1011, 5'd2, 1'b1, 1'b0, 1'b1));
      drive(OPI, 3'b101, 1'b0, 5'd1, 5'd0, 5'd2, 32'h80000000, 32'd0, 32'h005, 32'h408);
      send(mk(32'h80000000, 32'h005, 32'd0, 32'h408, 4'b1010, 5'd2, 1'b1, 1'b0, 1'b1));
      drive(OPI, 3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 32'd10, 32'd0, 32'd1, 32'h40C);
      send(mk(32'd10, 32'd1, 32'd0, 32'h40C, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b1));
      drive(7'b1111111, 3'b000, 1'b0, 5'd3, 5'd4, 5'd14, 32'h33, 32'h44, 32'd0, 32'h410);
      send(mk(32'h33, 32'd0, 32'h44, 32'h410, 4'b0111, 5'd14, 1'b0, 1'b1, 1'b0));
      exmem_we = 1'b1; exmem_rd = 5'd0; exmem_val = 32'd9;
      memwb_we = 1'b1; memwb_rd = 5'd0; memwb_val = 32'd8;
      drive(OP, 3'b000, 1'b0, 5'd0, 5'd2, 5'd15, 32'h77, 32'd4, 32'd0, 32'h414);
      send(mk(32'd0, 32'd4, 32'd4, 32'h414, 4'b0000, 5'd15, 1'b1, 1'b0, 1'b1));
      exmem_we = 1'b0; memwb_we = 1'b0;
      drain();

      // Reset mid-operation discards buffered entries
      out_ready = 1'b0;
      drive(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 32'h700);
      send(mk(32'd5, 32'd6, 32'd6, 32'h700, 4'b0000, 5'd3, 1'b1, 1'b0, 1'b1));
      rst_n = 1'b0;
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_alu_a", alu_a, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("final_queue", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
